adc_frame_writer: RTL
=====================

// Module: adc_frame_writer
// PURPOSE
//  Write-side framer in front of the ping-pong frame buffer. On a trigger it captures
//  one frame of ADC samples and drives the buffer write port (Wr_en/Wr_Addr/Wr_data/
//  Wr_frm_ok), honouring Wr_ready. Word 0 of every frame is a sequence header.
//  Samples come from the ADC deserializer; everything runs in the Wr_Clk domain.
// PARAMETERS
//  DATA_W     8    sample / RAM word width; matches buffer RAM_WIDTH
//  ADDR_BITS  14   buffer address width; matches buffer RAM_ADDR_BITS
//  GAP_MAX    16   max consecutive cycles with smp_valid_i low inside a frame before abort
// PORTS
//  Wr_Clk        in   1          write clock
//  reset         in   1          synchronous, active-high
//  trig_i        in   1          start-of-frame request, level sampled in IDLE
//  frm_len_i     in   ADDR_BITS  total words per frame incl. header; latched at trigger
//  smp_valid_i   in   1          smp_data_i valid this cycle
//  smp_data_i    in   DATA_W     ADC sample
//  Wr_ready_i    in   1          buffer ready for a new frame
//  Wr_en_o       out  1          buffer write enable, continuous high for a whole frame
//  Wr_Addr_o     out  ADDR_BITS  buffer write address
//  Wr_data_o     out  DATA_W     buffer write data
//  Wr_frm_ok_o   out  1          frame-good flag, valid in the first cycle Wr_en_o is low
//  busy_o        out  1          high in any state except IDLE
//  frm_seq_o     out  DATA_W     count of good frames (wraps)
//  drop_cnt_o    out  16         triggers refused (Wr_ready_i low), saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, len/gap/sequence registers cleared. Reset mid-frame
//   drops Wr_en_o at the next edge with Wr_frm_ok_o=0, so the buffer discards the frame.
//  States: IDLE -> WRITE -> CLOSE -> GAP -> IDLE.
//  IDLE: trig_i & Wr_ready_i -> WRITE. Latch len = max(frm_len_i, 2); frm_len_i=0 means
//   2^ADDR_BITS. Next cycle: Wr_en_o=1, Wr_Addr_o=0, Wr_data_o=frm_seq_o.
//   trig_i & !Wr_ready_i -> stay in IDLE, drop_cnt_o+1 once per rising edge of trig_i.
//  WRITE: Wr_en_o=1 throughout.
//   - smp_valid_i=1: the next cycle presents Wr_Addr_o+1 and smp_data_i, giving 1-cycle
//     latency.
//   - smp_valid_i=0: Wr_Addr_o and Wr_data_o hold; the rewrite of the same word is
//     harmless. gap_cnt increments and clears on any valid.
//   - gap_cnt reaches GAP_MAX: ok=0 and go to CLOSE.
//   - Last word presented (Wr_Addr_o = len-1 on an output cycle): ok=1 and go to CLOSE.
//     Samples arriving in that cycle or later are ignored.
//  CLOSE (1 cycle): Wr_en_o=0, Wr_frm_ok_o=ok, so the flag coincides with the buffer's
//   falling-edge detect. If ok, frm_seq_o+1 at the end of the cycle.
//  GAP (1 cycle): Wr_en_o=0, Wr_frm_ok_o=0. Guarantees >=2 low cycles between frames.
//   Then -> IDLE.
//  Address arithmetic is ADDR_BITS wide. With len=2^ADDR_BITS the last address is all
//   ones and never wraps.
//  trig_i during WRITE/CLOSE/GAP is ignored and not counted as dropped.
//  Wr_ready_i is only sampled in IDLE; the buffer drops it during writes by design.
// STRUCTURE
//  Package adc_frm_pkg: state encoding localparams (IDLE/WRITE/CLOSE/GAP), header
//   position constant HDR_ADDR=0, drop counter width 16.
//  One sub-module: frm_gap_timer (counter with clear/enable/expired at GAP_MAX), reused
//   by the read-side DMA. FSM, address counter and output registers stay in this module.
// TESTING
//  1 len=8, continuous valid, Wr_ready=1, trig pulse -> Wr_en high 8 cycles, addr 0..7,
//    word0=0x00, words 1..7 = samples; Wr_frm_ok=1 in the first low cycle; frm_seq_o=1.
//  2 len=8, valid low 3 cycles mid-frame (GAP_MAX=16) -> addr/data hold 3 cycles, frame
//    completes, ok=1, no duplicate or missing samples.
//  3 valid low 16 cycles mid-frame -> Wr_en falls after the 16th idle cycle, Wr_frm_ok=0,
//    frm_seq_o unchanged; the next frame header still uses the old sequence value.
//  4 Wr_ready=0, trig held 5 cycles then another pulse -> no Wr_en, drop_cnt_o=2; after
//    Wr_ready=1 the next trig writes normally.
//  5 Back-to-back triggers (trig tied high, Wr_ready=1) -> exactly 2 low Wr_en cycles
//    between frames; headers 0,1,2.
//  6 frm_len_i=1 -> 2-word frame. Reset asserted at addr 3 of len=8 -> Wr_en=0,
//    Wr_frm_ok=0 next cycle, all outputs 0.

Source files
------------

// File: rtl/adc_frm_pkg.sv
// Shared definitions for the ADC write-side framer: state encoding, header position and
// drop-counter width.
package adc_frm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLOSE = 2'd2,
        ST_GAP   = 2'd3
    } frm_state_e;

    localparam int HDR_ADDR = 0;
    localparam int DROP_W   = 16;

endpackage

// File: rtl/frm_gap_timer.sv
// Counts consecutive enabled cycles and flags the cycle in which the count would reach
// GAP_MAX. Shared by the write framer and the read-side DMA.
module frm_gap_timer #(
    parameter int GAP_MAX = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(GAP_MAX + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clr)
            count <= '0;
        else if (en)
            count <= count + CW'(1);
    end

    // Combinational so the owner can react on the very edge that sees the GAP_MAX-th idle cycle.
    assign expired = en && (count == CW'(GAP_MAX - 1));

endmodule

// File: rtl/adc_frame_writer.sv
// Write-side framer: on a trigger, writes a sequence header plus one frame of ADC samples
// into the ping-pong buffer write port, aborting on a long sample gap.
module adc_frame_writer
    import adc_frm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_BITS = 14,
    parameter int GAP_MAX   = 16
) (
    input  logic                 Wr_Clk,
    input  logic                 reset,
    input  logic                 trig_i,
    input  logic [ADDR_BITS-1:0] frm_len_i,
    input  logic                 smp_valid_i,
    input  logic [DATA_W-1:0]    smp_data_i,
    input  logic                 Wr_ready_i,
    output logic                 Wr_en_o,
    output logic [ADDR_BITS-1:0] Wr_Addr_o,
    output logic [DATA_W-1:0]    Wr_data_o,
    output logic                 Wr_frm_ok_o,
    output logic                 busy_o,
    output logic [DATA_W-1:0]    frm_seq_o,
    output logic [DROP_W-1:0]    drop_cnt_o
);

    frm_state_e           state;
    logic [ADDR_BITS-1:0] last_addr;
    logic [ADDR_BITS-1:0] len_last;
    logic                 trig_q;
    logic                 gap_clr;
    logic                 gap_en;
    logic                 gap_expired;

    // Last address of the requested frame: zero length means the full address space, and
    // anything shorter than header plus one sample is stretched to two words.
    always_comb begin
        len_last = frm_len_i - ADDR_BITS'(1);
        if (frm_len_i == '0)
            len_last = '1;
        else if (frm_len_i < ADDR_BITS'(2))
            len_last = ADDR_BITS'(1);
    end

    assign gap_en  = (state == ST_WRITE) && !smp_valid_i;
    assign gap_clr = (state != ST_WRITE) || smp_valid_i;

    frm_gap_timer #(
        .GAP_MAX (GAP_MAX)
    ) u_gap_timer (
        .clock   (Wr_Clk),
        .reset   (reset),
        .clr     (gap_clr),
        .en      (gap_en),
        .expired (gap_expired)
    );

    assign busy_o = (state != ST_IDLE);

    // Frame FSM with registered buffer-port outputs. GAP also acts as the start decision
    // point so back-to-back frames see exactly two low Wr_en cycles.
    always_ff @(posedge Wr_Clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_addr   <= '0;
            trig_q      <= 1'b0;
            Wr_en_o     <= 1'b0;
            Wr_Addr_o   <= '0;
            Wr_data_o   <= '0;
            Wr_frm_ok_o <= 1'b0;
            frm_seq_o   <= '0;
            drop_cnt_o  <= '0;
        end else begin
            trig_q <= trig_i;
            case (state)
                ST_IDLE, ST_GAP: begin
                    Wr_frm_ok_o <= 1'b0;
                    if (trig_i && Wr_ready_i) begin
                        state     <= ST_WRITE;
                        last_addr <= len_last;
                        Wr_en_o   <= 1'b1;
                        Wr_Addr_o <= ADDR_BITS'(HDR_ADDR);
                        Wr_data_o <= frm_seq_o;
                    end else begin
                        state <= ST_IDLE;
                        if (state == ST_IDLE && trig_i && !trig_q && drop_cnt_o != '1)
                            drop_cnt_o <= drop_cnt_o + DROP_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (Wr_Addr_o == last_addr) begin
                        state       <= ST_CLOSE;
                        Wr_en_o     <= 1'b0;
                        Wr_frm_ok_o <= 1'b1;
                    end else if (gap_expired) begin
                        state       <= ST_CLOSE;
                        Wr_en_o     <= 1'b0;
                        Wr_frm_ok_o <= 1'b0;
                    end else if (smp_valid_i) begin
                        Wr_Addr_o <= Wr_Addr_o + ADDR_BITS'(1);
                        Wr_data_o <= smp_data_i;
                    end
                end
                ST_CLOSE: begin
                    state       <= ST_GAP;
                    Wr_frm_ok_o <= 1'b0;
                    if (Wr_frm_ok_o)
                        frm_seq_o <= frm_seq_o + DATA_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
